// File: rtl/switch_input_port.sv
// switch_input_port: memory-mapped read-side peripheral for the board switches.
// Each switch is synchronized, then debounced. The port keeps a sticky per-switch
// change flag and a change-event counter, and presents them as four word registers.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   DataAdr    bus byte address
//   WriteData  bus write data
//   MemWrite   bus write strobe, sampled on rising clk
//   switches   asynchronous board switches (N bits)
//   ReadData   combinational read data; 0 when SwSel is low
//   SwSel      DataAdr lies in [BASE_ADR, BASE_ADR+15]
//
// Register map (offset from BASE_ADR; DataAdr[1:0] ignored):
//   0x0 SW_VALUE   RO     debounced value
//   0x4 SW_CHANGED R/W1C  sticky per-bit change flags
//   0x8 SW_RAW     RO     second synchronizer stage
//   0xC CHG_COUNT  R/W    [15:0] change-cycle counter; any write clears it
module switch_input_port #(
    parameter int unsigned N               = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] BASE_ADR        = 32'h0000_0400
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  DataAdr,
    input  logic [31:0]  WriteData,
    input  logic         MemWrite,
    input  logic [N-1:0] switches,
    output logic [31:0]  ReadData,
    output logic         SwSel
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  deb_q, deb_d;
    logic [N-1:0]  changed_q, changed_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [15:0]   count_q, count_d;

    logic [N-1:0]  chg;
    logic [32:0]   adr_ext;
    logic [32:0]   base_ext;
    logic [31:0]   offset;
    logic          wr_en;
    logic          wr_changed;
    logic          wr_count;
    logic          unused_bits;

    // Address decode. The 33-bit compare keeps a window near the top of the
    // address space from wrapping around.
    always_comb begin
        adr_ext  = {1'b0, DataAdr};
        base_ext = {1'b0, BASE_ADR};
        SwSel    = (adr_ext >= base_ext) && (adr_ext <= base_ext + 33'd15);
        offset   = DataAdr - BASE_ADR;
        wr_en    = MemWrite & SwSel;
        wr_changed = wr_en && (offset[3:2] == 2'd1);
        wr_count   = wr_en && (offset[3:2] == 2'd3);
    end

    // Synchronizer and per-bit debounce counters.
    always_comb begin
        sync1_d = switches;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        chg     = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                // Any return to agreement discards partial progress.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
                chg[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Sticky flags and event counter. A new change wins over a same-cycle write.
    always_comb begin
        changed_d = chg | (changed_q & ~(WriteData[N-1:0] & {N{wr_changed}}));
        count_d   = count_q;
        if (wr_count) begin
            count_d = (|chg) ? 16'd1 : 16'd0;
        end else if (|chg) begin
            count_d = count_q + 16'd1;
        end
    end

    // Read mux.
    always_comb begin
        ReadData = '0;
        if (SwSel) begin
            case (offset[3:2])
                2'd0:    ReadData = 32'(deb_q);
                2'd1:    ReadData = 32'(changed_q);
                2'd2:    ReadData = 32'(sync2_q);
                default: ReadData = {16'd0, count_q};
            endcase
        end
    end

    // Address LSBs and WriteData bits above N carry no meaning here.
    assign unused_bits = ^{offset, WriteData};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            changed_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            changed_q <= changed_d;
            count_q   <= count_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: doc/switch_input_port.md
# switch_input_port

Memory-mapped read-side peripheral: the input counterpart of the LED output port. Synchronizes and debounces the board `switches`, keeps sticky per-switch change flags and a change-event counter, and serves them to the processor data bus as word registers. It sits next to the LED port behind the data-memory address decoder in `top`.

## Interface

Parameters:
- `N`, 10, number of switch inputs (1..32).
- `DEBOUNCE_CYCLES`, 4, consecutive cycles a synchronized bit must differ from its debounced value before the debounced value updates (≥1).
- `BASE_ADR`, 32'h0000_0400, word-aligned base of the 16-byte register window.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `DataAdr`  in  32  bus byte address.
- `WriteData`  in  32  bus write data.
- `MemWrite`  in  1  bus write strobe, sampled on rising `clk`.
- `switches`  in  N  asynchronous board switches.
- `ReadData`  out  32  read data, combinational from `DataAdr`.
- `SwSel`  out  1  high when `DataAdr` falls in `[BASE_ADR, BASE_ADR+15]`; the top uses it to mux `ReadData`.

## Operation

Register map (offset from `BASE_ADR`, `DataAdr[1:0]` ignored):
- 0x0 SW_VALUE, RO: debounced value, zero-extended.
- 0x4 SW_CHANGED, R/W1C: sticky flag per bit, set when that debounced bit changes; writing 1 clears, 0 has no effect.
- 0x8 SW_RAW, RO: second synchronizer stage, zero-extended.
- 0xC CHG_COUNT, R/W: bits [15:0] count cycles in which ≥1 debounced bit changed, wrapping 0xFFFF→0x0000; any write clears it; bits [31:16] read 0.

Datapath:
- Two-flop synchronizer per bit: `sync1 <= switches`, `sync2 <= sync1`.
- Per-bit counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync2[i] == deb[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `deb[i] <= sync2[i]`, `cnt[i] <= 0`, raise `chg[i]` for this edge.
  - Else: `cnt[i] <= cnt[i]+1`.
- `SW_CHANGED[i] <= chg[i] | (SW_CHANGED[i] & ~(wr_changed & WriteData[i]))`. Set wins over a same-cycle clear.
- CHG_COUNT: if written and `|chg` in the same cycle, the result is 1. Otherwise write→0, `|chg`→+1, else hold.
- Writes are accepted only when `MemWrite & SwSel`. Writes to 0x0/0x8 are ignored.
- `ReadData` is 0 when `SwSel` is low. Bits above N read 0.

Reset (synchronous, `reset`=1 at a rising edge):
- sync1, sync2, deb, cnt, SW_CHANGED, CHG_COUNT all set to 0.
- Reset mid-debounce discards progress. A switch held at 1 through reset produces a full debounce, a flag set, and count=1 after release.

## Timing

- A `switches` change sampled at edge k is visible in SW_RAW after edge k+1.
- SW_VALUE, SW_CHANGED and CHG_COUNT update at edge k+1+DEBOUNCE_CYCLES (edge k+5 with the default), provided `sync2` is stable meanwhile.
- A pulse lasting fewer than DEBOUNCE_CYCLES cycles at `sync2` never reaches `deb`. Any return to equality restarts the count.
- Reads: zero-latency combinational, reflecting register state after the last edge.
- Writes: take effect at the same rising edge `MemWrite` is sampled.
- Multiple bits settling in the same cycle increment CHG_COUNT by exactly 1.

## Test plan

- Reset: hold `reset`=1 for 2 cycles with `switches`=10'h3FF, then release. All four registers read 0 immediately; SW_VALUE reads 0x3FF 6 cycles after release; CHG_COUNT=1; SW_CHANGED=0x3FF.
- Stable input: `switches`=10'd25 from reset → SW_VALUE=25 after 1+DEBOUNCE_CYCLES edges past the sample edge; SW_CHANGED=0x19; CHG_COUNT=1; unmapped address 0x0 gives `SwSel`=0, `ReadData`=0.
- Glitch: bit 3 high for 3 cycles, then low → SW_RAW briefly shows 0x8; SW_VALUE, SW_CHANGED and CHG_COUNT unchanged. Bit 3 held 4+ cycles → SW_VALUE bit 3 = 1.
- W1C: with SW_CHANGED=0x19, write 0x08 to offset 0x4 → reads 0x11. Write 0 → 0x11 unchanged.
- Same-cycle set/clear: write 0x1 to 0x4 on the debounce edge of bit 0 → bit 0 stays 1. Write 0xC on a change edge → CHG_COUNT=1.
- Wrap: force 65536 debounced toggles on bit 0, or preload via a write-then-toggle sequence → CHG_COUNT reads 0x0000 after the 65536th change; writes to 0x0/0x8 leave values unchanged.
